multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter: HALT_ON_ILLEGAL, default 1, 1 = illegal opcode parks the FSM in HALT; 0 = illegal opcode returns to FETCH.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 op  input  7  opcode field of the instruction register, instr[6:0].
REQ-005 funct3  input  3  instr[14:12].
REQ-006 funct7b5  input  1  instr[30].
REQ-007 Zero  input  1  ALU zero flag.
REQ-008 mem_ready  input  1  unified memory has completed the current read or write.
REQ-009 PCWrite  output  1  PC register load enable.
REQ-010 AdrSrc  output  1  memory address source: 0 = PC, 1 = ALUOut.
REQ-011 MemWrite  output  1  memory write strobe.
REQ-012 IRWrite  output  1  instruction register (and OldPC) load enable.
REQ-013 RegWrite  output  1  register-file write enable.
REQ-014 ResultSrc  output  2  result source: 00 ALUOut, 01 ReadData, 10 ALUResult.
REQ-015 ALUSrcA  output  2  ALU operand A: 00 PC, 01 OldPC, 10 rs1.
REQ-016 ALUSrcB  output  2  ALU operand B: 00 rs2, 01 Imm_Ext, 10 constant 4.
REQ-017 ALUControl  output  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-018 ImmSrc  output  2  immediate format for the extender: 00 I, 01 S, 10 B, 11 J.
REQ-019 illegal  output  1  sticky flag, set when an unsupported opcode is decoded.

Function
REQ-020 The FSM SHALL have states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL and HALT.
REQ-021 FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUControl=add, ResultSrc=10, PCWrite=1; these outputs hold until mem_ready=1, and the state then moves to DECODE.
REQ-022 In FETCH, IRWrite and PCWrite SHALL be asserted only in the cycle where mem_ready=1, so each instruction causes exactly one PC+4.
REQ-023 DECODE: ALUSrcA=01, ALUSrcB=01, ImmSrc=10, ALUControl=add (branch target precompute); next state by op: 0000011/0100011 -> MEMADR, 0110011 -> EXECUTER, 0010011 -> EXECUTEI, 1100011 -> BEQ, 1101111 -> JAL, any other op -> illegal handling.
REQ-024 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUControl=add, ImmSrc=00 for lw and 01 for sw; next state MEMREAD for lw, MEMWRITE for sw.
REQ-025 MEMREAD: ResultSrc=00, AdrSrc=1; wait for mem_ready, then go to MEMWB.
REQ-026 MEMWB: ResultSrc=01, RegWrite=1 for one cycle, then FETCH.
REQ-027 MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1 until mem_ready=1, then FETCH.
REQ-028 EXECUTER and EXECUTEI: ALUSrcA=10, ALUSrcB=00 (R-type) or 01 with ImmSrc=00 (I-type); then ALUWB.
REQ-029 ALUControl decode for EXECUTER/EXECUTEI by funct3: 000 -> sub only when R-type and funct7b5=1, else add; 010 -> slt; 110 -> or; 111 -> and; any other funct3 -> illegal handling.
REQ-030 ALUWB: ResultSrc=00, RegWrite=1 for one cycle, then FETCH.
REQ-031 BEQ: ALUSrcA=10, ALUSrcB=00, ALUControl=sub, ResultSrc=00; PCWrite=Zero for that same cycle; then FETCH.
REQ-032 JAL: ALUSrcA=01, ALUSrcB=10, ALUControl=add, ResultSrc=00, PCWrite=1; then ALUWB.
REQ-033 Illegal handling: illegal is set; the next state is HALT if HALT_ON_ILLEGAL=1, otherwise FETCH. No write strobe is asserted in the decoding cycle.
REQ-034 HALT: all enables 0; HALT is exited only by reset.
REQ-035 Every enable (PCWrite, IRWrite, MemWrite, RegWrite) not named for a state SHALL be 0 in that state; every mux select not named for a state SHALL be 0.
REQ-036 All outputs SHALL be combinational from the current state and inputs (Moore, except for the Zero and mem_ready qualification).

Reset
REQ-037 While rst=0: state=FETCH, illegal=0, all enables 0; reset takes effect immediately, including mid-instruction or while stalled on mem_ready.
REQ-038 The first FETCH after rst deasserts SHALL behave identically to any later FETCH.

Structure
REQ-039 The state encoding, opcode constants, and the ALUControl, ImmSrc, ResultSrc and ALUSrc encodings SHALL live in the shared package riscv_ctrl_pkg.
REQ-040 ALU operation decode SHALL be the combinational sub-module alu_decoder (inputs: ALUOp class, funct3, funct7b5, op[5]; output: ALUControl).

Verification
REQ-041 lw (op 0000011), mem_ready=1 throughout -> FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 and ResultSrc=01 in cycle 5 only.
REQ-042 sw with mem_ready held low 3 cycles in MEMWRITE -> MemWrite=1 for 4 cycles, ImmSrc=01 in MEMADR, then FETCH.
REQ-043 beq with Zero=1, then again with Zero=0 -> PCWrite=1 in BEQ for the first, PCWrite=0 for the second; ALUControl=001 in both.
REQ-044 R-type sub (funct3 000, funct7b5=1) -> ALUControl=001; I-type addi with funct7b5=1 -> ALUControl=000.
REQ-045 op 1111111 with HALT_ON_ILLEGAL=1 -> illegal=1, state HALT, all enables 0 for 10+ cycles; with HALT_ON_ILLEGAL=0 -> FETCH.
REQ-046 Assert rst=0 during MEMREAD stall -> outputs reset asynchronously before the next clk edge; after release, PCWrite pulses on the first mem_ready.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared encodings for the multicycle RISC-V control path
package riscv_ctrl_pkg;

   // FSM state encoding
   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_MEMADR   = 4'd2;
   localparam logic [3:0] S_MEMREAD  = 4'd3;
   localparam logic [3:0] S_MEMWB    = 4'd4;
   localparam logic [3:0] S_MEMWRITE = 4'd5;
   localparam logic [3:0] S_EXECUTER = 4'd6;
   localparam logic [3:0] S_EXECUTEI = 4'd7;
   localparam logic [3:0] S_ALUWB    = 4'd8;
   localparam logic [3:0] S_BEQ      = 4'd9;
   localparam logic [3:0] S_JAL      = 4'd10;
   localparam logic [3:0] S_HALT     = 4'd11;

   // Supported opcodes
   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   // ALU operation class handed from the FSM to the ALU decoder
   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } alu_op_e;

   // ALUControl encoding
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   // ImmSrc encoding
   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   // ResultSrc encoding
   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_READDATA  = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   // ALUSrcA / ALUSrcB encodings
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;
   localparam logic [1:0] SRCB_RS2   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

   // funct3 values the ALU decoder understands for R/I-type arithmetic
   function automatic logic funct3_supported(input logic [2:0] f3);
      return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - combinational ALU operation decode from op class and funct fields
module alu_decoder
   import riscv_ctrl_pkg::*;
(
   input  alu_op_e    alu_op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       op5,
   output logic [2:0] alu_control
);

   // Fixed add/sub for address and branch work, funct3 decode for arithmetic
   always_comb begin
      alu_control = ALU_ADD;
      case (alu_op)
         ALUOP_ADD: alu_control = ALU_ADD;
         ALUOP_SUB: alu_control = ALU_SUB;
         default: begin
            case (funct3)
               // funct7b5 only selects sub for R-type; addi has imm bits there
               3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_control = ALU_SLT;
               3'b110:  alu_control = ALU_OR;
               3'b111:  alu_control = ALU_AND;
               default: alu_control = ALU_ADD;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle RISC-V control FSM with memory handshake
module multicycle_controller
   import riscv_ctrl_pkg::*;
#(
   parameter bit HALT_ON_ILLEGAL = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       Zero,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUControl,
   output logic [1:0] ImmSrc,
   output logic       illegal
);

   logic [3:0] state;
   logic [3:0] state_next;
   logic       illegal_q;
   logic       illegal_set;
   alu_op_e    alu_op;
   logic       pc_write_raw;
   logic       ir_write_raw;
   logic       mem_write_raw;
   logic       reg_write_raw;
   logic [3:0] illegal_dest;

   assign illegal_dest = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;

   alu_decoder u_alu_decoder (
      .alu_op      (alu_op),
      .funct3      (funct3),
      .funct7b5    (funct7b5),
      .op5         (op[5]),
      .alu_control (ALUControl)
   );

   // Next-state and per-state output decode; everything not named stays 0
   always_comb begin
      state_next    = state;
      illegal_set   = 1'b0;
      alu_op        = ALUOP_ADD;
      pc_write_raw  = 1'b0;
      ir_write_raw  = 1'b0;
      mem_write_raw = 1'b0;
      reg_write_raw = 1'b0;
      AdrSrc        = 1'b0;
      ResultSrc     = RES_ALUOUT;
      ALUSrcA       = SRCA_PC;
      ALUSrcB       = SRCB_RS2;
      ImmSrc        = IMM_I;
      case (state)
         S_FETCH: begin
            ALUSrcA   = SRCA_PC;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
            // Load IR and PC+4 only on the completing cycle: one increment per fetch
            ir_write_raw = mem_ready;
            pc_write_raw = mem_ready;
            if (mem_ready) state_next = S_DECODE;
         end
         S_DECODE: begin
            // Precompute the branch target into ALUOut
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            ImmSrc  = IMM_B;
            case (op)
               OP_LW, OP_SW: state_next = S_MEMADR;
               OP_RTYPE:     state_next = S_EXECUTER;
               OP_ITYPE:     state_next = S_EXECUTEI;
               OP_BEQ:       state_next = S_BEQ;
               OP_JAL:       state_next = S_JAL;
               default: begin
                  illegal_set = 1'b1;
                  state_next  = illegal_dest;
               end
            endcase
         end
         S_MEMADR: begin
            ALUSrcA    = SRCA_RS1;
            ALUSrcB    = SRCB_IMM;
            ImmSrc     = (op == OP_SW) ? IMM_S : IMM_I;
            state_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            AdrSrc    = 1'b1;
            ResultSrc = RES_ALUOUT;
            if (mem_ready) state_next = S_MEMWB;
         end
         S_MEMWB: begin
            ResultSrc     = RES_READDATA;
            reg_write_raw = 1'b1;
            state_next    = S_FETCH;
         end
         S_MEMWRITE: begin
            AdrSrc        = 1'b1;
            ResultSrc     = RES_ALUOUT;
            mem_write_raw = 1'b1;
            if (mem_ready) state_next = S_FETCH;
         end
         S_EXECUTER, S_EXECUTEI: begin
            alu_op  = ALUOP_FUNCT;
            ALUSrcA = SRCA_RS1;
            ALUSrcB = (state == S_EXECUTEI) ? SRCB_IMM : SRCB_RS2;
            ImmSrc  = IMM_I;
            if (funct3_supported(funct3)) begin
               state_next = S_ALUWB;
            end else begin
               illegal_set = 1'b1;
               state_next  = illegal_dest;
            end
         end
         S_ALUWB: begin
            ResultSrc     = RES_ALUOUT;
            reg_write_raw = 1'b1;
            state_next    = S_FETCH;
         end
         S_BEQ: begin
            alu_op       = ALUOP_SUB;
            ALUSrcA      = SRCA_RS1;
            ALUSrcB      = SRCB_RS2;
            ResultSrc    = RES_ALUOUT;
            pc_write_raw = Zero;
            state_next   = S_FETCH;
         end
         S_JAL: begin
            // PC takes the target from ALUOut while the ALU forms OldPC+4 for rd
            ALUSrcA      = SRCA_OLDPC;
            ALUSrcB      = SRCB_FOUR;
            ResultSrc    = RES_ALUOUT;
            pc_write_raw = 1'b1;
            state_next   = S_ALUWB;
         end
         S_HALT: begin
            state_next = S_HALT;
         end
         default: begin
            state_next = S_FETCH;
         end
      endcase
   end

   // Enables are forced low for the whole time reset is held, not just at the edge
   assign PCWrite  = rst & pc_write_raw;
   assign IRWrite  = rst & ir_write_raw;
   assign MemWrite = rst & mem_write_raw;
   assign RegWrite = rst & reg_write_raw;
   assign illegal  = illegal_q;

   // State register and sticky illegal flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_FETCH;
         illegal_q <= 1'b0;
      end else begin
         state <= state_next;
         if (illegal_set) illegal_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for the multicycle controller
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       Zero;
   logic       mem_ready;

   // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,ImmSrc,illegal}
   wire [16:0] v0;
   wire [16:0] v1;

   typedef struct {
      bit          sel;
      logic [16:0] v;
      string       nm;
   } exp_t;

   exp_t        q[$];
   exp_t        me;
   logic [16:0] act;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   multicycle_controller #(.HALT_ON_ILLEGAL(1'b1)) dut0 (
      .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .Zero(Zero), .mem_ready(mem_ready),
      .PCWrite(v0[16]), .AdrSrc(v0[15]), .MemWrite(v0[14]), .IRWrite(v0[13]),
      .RegWrite(v0[12]), .ResultSrc(v0[11:10]), .ALUSrcA(v0[9:8]), .ALUSrcB(v0[7:6]),
      .ALUControl(v0[5:3]), .ImmSrc(v0[2:1]), .illegal(v0[0])
   );

   multicycle_controller #(.HALT_ON_ILLEGAL(1'b0)) dut1 (
      .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .Zero(Zero), .mem_ready(mem_ready),
      .PCWrite(v1[16]), .AdrSrc(v1[15]), .MemWrite(v1[14]), .IRWrite(v1[13]),
      .RegWrite(v1[12]), .ResultSrc(v1[11:10]), .ALUSrcA(v1[9:8]), .ALUSrcB(v1[7:6]),
      .ALUControl(v1[5:3]), .ImmSrc(v1[2:1]), .illegal(v1[0])
   );

   function automatic logic [16:0] ev(input logic pcw, input logic adr, input logic mw,
                                      input logic irw, input logic rw, input logic [1:0] rs,
                                      input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [2:0] alu, input logic [1:0] imm,
                                      input logic ill);
      return {pcw, adr, mw, irw, rw, rs, sa, sb, alu, imm, ill};
   endfunction

   // Monitor: mid-cycle, pop every expectation queued for this cycle and compare
   always @(negedge clk) begin
      while (q.size() > 0) begin
         me  = q.pop_front();
         act = me.sel ? v1 : v0;
         total++;
         if (act !== me.v) begin
            bad++;
            $display("FAIL %s dut%0d: got %b want %b", me.nm, me.sel, act, me.v);
         end
      end
   end

   task automatic push(input bit sel, input logic [16:0] v, input string nm);
      exp_t e;
      e.sel = sel;
      e.v   = v;
      e.nm  = nm;
      q.push_back(e);
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input logic mr, input logic z, input logic [16:0] v, input string nm);
      mem_ready = mr;
      Zero      = z;
      push(1'b0, v, nm);
      advance();
   endtask

   task automatic fetch_decode(input logic [6:0] o, input logic [2:0] f3, input logic f7);
      op       = o;
      funct3   = f3;
      funct7b5 = f7;
      cyc(1'b1, 1'b0, ev(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b00,0), "fetch");
      cyc(1'b1, 1'b0, ev(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b10,0), "decode");
   endtask

   logic [2:0] r_f3  [5] = '{3'b000, 3'b000, 3'b010, 3'b110, 3'b111};
   logic       r_f7  [5] = '{1'b1,   1'b0,   1'b0,   1'b0,   1'b0};
   logic [2:0] r_alu [5] = '{3'b001, 3'b000, 3'b101, 3'b011, 3'b010};
   logic [2:0] i_f3  [4] = '{3'b000, 3'b010, 3'b110, 3'b111};
   logic       i_f7  [4] = '{1'b1,   1'b0,   1'b0,   1'b0};
   logic [2:0] i_alu [4] = '{3'b000, 3'b101, 3'b011, 3'b010};

   initial begin
      rst = 1'b0; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0; mem_ready = 1'b1;
      advance();
      // Reset held with mem_ready high: FETCH selects, no enables
      push(1'b1, ev(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b00,0), "reset_state_nohalt");
      cyc(1'b1, 1'b0, ev(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b00,0), "reset_state");
      rst = 1'b1;

      // Fetch stall: no PC/IR write until mem_ready
      cyc(1'b0, 1'b0, ev(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b00,0), "fetch_stall");
      cyc(1'b0, 1'b0, ev(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b00,0), "fetch_stall");

      // lw
      fetch_decode(7'b0000011, 3'b010, 1'b0);
      cyc(1'b1, 1'b0, ev(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b00,0), "lw_memadr");
      cyc(1'b1, 1'b0, ev(0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0), "lw_memread");
      cyc(1'b1, 1'b0, ev(0,0,0,0,1,2'b01,2'b00,2'b00,3'b000,2'b00,0), "lw_memwb");

      // sw with three wait cycles
      fetch_decode(7'b0100011, 3'b010, 1'b0);
      cyc(1'b1, 1'b0, ev(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b01,0), "sw_memadr");
      repeat (3) cyc(1'b0, 1'b0, ev(0,1,1,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0), "sw_wait");
      cyc(1'b1, 1'b0, ev(0,1,1,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0), "sw_done");

      // beq taken, then not taken
      fetch_decode(7'b1100011, 3'b000, 1'b0);
      cyc(1'b1, 1'b1, ev(1,0,0,0,0,2'b00,2'b10,2'b00,3'b001,2'b00,0), "beq_taken");
      fetch_decode(7'b1100011, 3'b000, 1'b0);
      cyc(1'b1, 1'b0, ev(0,0,0,0,0,2'b00,2'b10,2'b00,3'b001,2'b00,0), "beq_not_taken");

      // R-type ALU decode
      for (int i = 0; i < 5; i++) begin
         fetch_decode(7'b0110011, r_f3[i], r_f7[i]);
         cyc(1'b1, 1'b0, ev(0,0,0,0,0,2'b00,2'b10,2'b00,r_alu[i],2'b00,0), "rtype_exec");
         cyc(1'b1, 1'b0, ev(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,2'b00,0), "rtype_aluwb");
      end

      // I-type ALU decode (funct7b5 must not turn addi into sub)
      for (int i = 0; i < 4; i++) begin
         fetch_decode(7'b0010011, i_f3[i], i_f7[i]);
         cyc(1'b1, 1'b0, ev(0,0,0,0,0,2'b00,2'b10,2'b01,i_alu[i],2'b00,0), "itype_exec");
         cyc(1'b1, 1'b0, ev(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,2'b00,0), "itype_aluwb");
      end

      // jal
      fetch_decode(7'b1101111, 3'b000, 1'b0);
      cyc(1'b1, 1'b0, ev(1,0,0,0,0,2'b00,2'b01,2'b10,3'b000,2'b00,0), "jal");
      cyc(1'b1, 1'b0, ev(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,2'b00,0), "jal_aluwb");

      // Illegal opcode: dut0 halts, dut1 returns to FETCH
      fetch_decode(7'b1111111, 3'b000, 1'b0);
      mem_ready = 1'b1; Zero = 1'b1;
      push(1'b0, ev(0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,1), "halt");
      push(1'b1, ev(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b00,1), "nohalt_fetch");
      advance();
      push(1'b1, ev(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b10,1), "nohalt_decode");
      cyc(1'b1, 1'b1, ev(0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,1), "halt");
      op = 7'b0000011;
      repeat (10) cyc(1'b1, 1'b1, ev(0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,1), "halt_hold");

      // Reset clears the sticky flag and leaves HALT
      rst = 1'b0;
      push(1'b1, ev(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b00,0), "reset_clear_nohalt");
      cyc(1'b1, 1'b0, ev(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b00,0), "reset_clear");
      rst = 1'b1;

      // Unsupported funct3 on R-type is illegal too
      fetch_decode(7'b0110011, 3'b001, 1'b0);
      cyc(1'b1, 1'b0, ev(0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,2'b00,0), "bad_f3_exec");
      push(1'b1, ev(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b00,1), "bad_f3_nohalt");
      cyc(1'b1, 1'b0, ev(0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,1), "bad_f3_halt");
      rst = 1'b0;
      cyc(1'b1, 1'b0, ev(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b00,0), "reset_clear2");
      rst = 1'b1;

      // Asynchronous reset during a MEMREAD stall
      fetch_decode(7'b0000011, 3'b010, 1'b0);
      cyc(1'b1, 1'b0, ev(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b00,0), "lw2_memadr");
      cyc(1'b0, 1'b0, ev(0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0), "lw2_memread_stall");
      rst = 1'b0;
      cyc(1'b1, 1'b0, ev(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b00,0), "async_reset");
      rst = 1'b1;
      cyc(1'b0, 1'b0, ev(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b00,0), "post_reset_stall");
      cyc(1'b1, 1'b0, ev(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b00,0), "post_reset_fetch");
      cyc(1'b1, 1'b0, ev(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b10,0), "post_reset_decode");

      @(negedge clk);
      #1;
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
